// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing unit.
package pipeline_ctrl_pkg;

  // Bit positions of the inter-stage registers in the stall/flush vectors.
  localparam int unsigned IF_ID  = 0;
  localparam int unsigned ID_EX  = 1;
  localparam int unsigned EX_MEM = 2;
  localparam int unsigned MEM_WB = 3;

  // MDU occupancy of the EX stage.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Width of the MDU down-counter; it only ever holds values up to MDU_LAT-2.
  function automatic int unsigned mdu_cnt_width(input int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_mdu_seq.sv
// MDU sequencer: launches a multi-cycle MUL/DIV op from EX, counts its
// latency, and holds the result in DONE until MEM can accept it.
module mdu_seq
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_mdu,
  input  logic hold,
  input  logic kill,
  output logic mdu_busy,
  output logic mdu_start,
  output logic mdu_kill,
  output logic mdu_done
);

  localparam int unsigned CW = mdu_cnt_width(MDU_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 2);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state and pulse decode; START is the first stall cycle, so BUSY
  // only needs MDU_LAT-1 further cycles (counted MDU_LAT-2 down to 0).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_busy  = 1'b0;
    mdu_start = 1'b0;
    mdu_kill  = 1'b0;
    mdu_done  = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_mdu && !kill && !hold) begin
          mdu_start = 1'b1;
          mdu_busy  = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        mdu_busy = 1'b1;
        if (kill) begin
          mdu_kill = 1'b1;
          state_d  = RUN;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        mdu_done = 1'b1;
        if (kill) begin
          mdu_kill = 1'b1;
          state_d  = RUN;
        end else if (!hold) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // The MDU itself is reset by rst, so no pulses are issued while it is high.
    if (rst) begin
      mdu_busy  = 1'b0;
      mdu_start = 1'b0;
      mdu_kill  = 1'b0;
      mdu_done  = 1'b0;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing unit for the 5-stage in-order pipeline:
// prioritised stall/flush generation plus a stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_rs1_en,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs2_en,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mdu,
  input  logic             ex_redirect,
  input  logic             mem_trap,
  output logic             pc_stall,
  output logic [3:0]       stall,
  output logic [3:0]       flush,
  output logic             mdu_start,
  output logic             mdu_kill,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             mdu_busy;
  logic             load_use;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  mdu_seq #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_seq (
    .clk      (clk),
    .rst      (rst),
    .ex_mdu   (ex_mdu),
    .hold     (dmem_wait),
    .kill     (mem_trap),
    .mdu_busy (mdu_busy),
    .mdu_start(mdu_start),
    .mdu_kill (mdu_kill),
    .mdu_done (mdu_done)
  );

  // Load in EX whose destination is read by ID; x0 never creates a hazard.
  always_comb begin
    load_use = ex_is_load && (ex_rd != '0) &&
               ((id_rs1_en && (id_rs1 == ex_rd)) ||
                (id_rs2_en && (id_rs2 == ex_rd)));
  end

  // Priority encoder: exactly one row drives stall/flush/pc_stall.
  always_comb begin
    stall    = '0;
    flush    = '0;
    pc_stall = 1'b0;
    if (rst) begin
      flush    = '1;
      pc_stall = 1'b1;
    end else if (mem_trap) begin
      flush = '1;
    end else if (dmem_wait) begin
      stall[IF_ID]  = 1'b1;
      stall[ID_EX]  = 1'b1;
      stall[EX_MEM] = 1'b1;
      flush[MEM_WB] = 1'b1;
      pc_stall      = 1'b1;
    end else if (mdu_busy) begin
      stall[IF_ID]  = 1'b1;
      stall[ID_EX]  = 1'b1;
      flush[EX_MEM] = 1'b1;
      pc_stall      = 1'b1;
    end else if (ex_redirect) begin
      flush[IF_ID] = 1'b1;
      flush[ID_EX] = 1'b1;
    end else if (load_use) begin
      stall[IF_ID] = 1'b1;
      flush[ID_EX] = 1'b1;
      pc_stall     = 1'b1;
    end else if (imem_wait) begin
      flush[IF_ID] = 1'b1;
      pc_stall     = 1'b1;
    end
  end

  // Stall-cycle counter next value; wraps naturally at 2^CNT_W.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_stall) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MDU_LAT=4), plus a narrow
// CNT_W=2 instance sharing the same inputs to exercise counter wrap.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_wait, dmem_wait;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_en, id_rs2_en, ex_is_load, ex_mdu, ex_redirect, mem_trap;

  logic        pc_stall, mdu_start, mdu_kill, mdu_done;
  logic [3:0]  stall, flush;
  logic [31:0] stall_cycles;

  logic        pc_stall2, mdu_start2, mdu_kill2, mdu_done2;
  logic [3:0]  stall2, flush2;
  logic [1:0]  stall_cycles2;

  // {pc_stall, stall[3:0], flush[3:0], mdu_start, mdu_kill, mdu_done}
  logic [11:0] obs;
  assign obs = {pc_stall, stall, flush, mdu_start, mdu_kill, mdu_done};

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MDU_LAT(4), .CNT_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mdu(ex_mdu),
    .ex_redirect(ex_redirect), .mem_trap(mem_trap),
    .pc_stall(pc_stall), .stall(stall), .flush(flush), .mdu_start(mdu_start),
    .mdu_kill(mdu_kill), .mdu_done(mdu_done), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.MDU_LAT(4), .CNT_W(2), .REG_W(5)) dut_w2 (
    .clk(clk), .rst(rst), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mdu(ex_mdu),
    .ex_redirect(ex_redirect), .mem_trap(mem_trap),
    .pc_stall(pc_stall2), .stall(stall2), .flush(flush2), .mdu_start(mdu_start2),
    .mdu_kill(mdu_kill2), .mdu_done(mdu_done2), .stall_cycles(stall_cycles2)
  );

  task automatic idle();
    imem_wait = 0; dmem_wait = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_rs1_en = 0; id_rs2_en = 0; ex_is_load = 0; ex_mdu = 0;
    ex_redirect = 0; mem_trap = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    // Launch an MDU op, then assert reset mid-cycle while in BUSY.
    ex_mdu = 1;
    @(negedge clk);
    #2 rst = 1; ex_mdu = 0;
    #1;
    checks++;
    if (obs !== 12'b1_0000_1111_000)
      $display("FAIL reset_outputs: obs=%b exp=%b", obs, 12'b1_0000_1111_000);
    else passes++;
    checks++;
    if (stall_cycles !== 32'd0)
      $display("FAIL reset_counter: stall_cycles=%0d exp=0", stall_cycles);
    else passes++;
    @(negedge clk); rst = 0;
    #1;
    checks++;
    if (obs !== 12'b0)
      $display("FAIL reset_release_idle: obs=%b exp=%b", obs, 12'b0);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if (obs !== 12'b0)
      $display("FAIL reset_state_run: obs=%b exp=%b", obs, 12'b0);
    else passes++;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_rs2_en = 1; id_rs1 = 3; id_rs1_en = 1;
    #1;
    checks++;
    if (obs !== 12'b1_0001_0010_000)
      $display("FAIL load_use_rs2: obs=%b exp=%b", obs, 12'b1_0001_0010_000);
    else passes++;
    @(negedge clk);
    id_rs2_en = 0; id_rs1 = 5;
    #1;
    checks++;
    if (obs !== 12'b1_0001_0010_000)
      $display("FAIL load_use_rs1: obs=%b exp=%b", obs, 12'b1_0001_0010_000);
    else passes++;
    @(negedge clk);
    id_rs1 = 0; id_rs2 = 0; id_rs2_en = 1; ex_rd = 0;
    #1;
    checks++;
    if (obs !== 12'b0)
      $display("FAIL load_use_x0: obs=%b exp=%b", obs, 12'b0);
    else passes++;
    @(negedge clk);
    ex_rd = 5; id_rs1 = 5; id_rs1_en = 0; id_rs2 = 5; id_rs2_en = 0;
    #1;
    checks++;
    if (obs !== 12'b0)
      $display("FAIL load_use_disabled: obs=%b exp=%b", obs, 12'b0);
    else passes++;
    checks++;
    if (stall_cycles !== 32'd2)
      $display("FAIL load_use_count: stall_cycles=%0d exp=2", stall_cycles);
    else passes++;
  endtask

  task automatic test_mdu();
    logic [11:0] exp;
    do_reset();
    ex_mdu = 1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp = (c == 0) ? 12'b1_0011_0100_100 :
            (c < 4)  ? 12'b1_0011_0100_000 : 12'b0_0000_0000_001;
      checks++;
      if (obs !== exp)
        $display("FAIL mdu_cycle%0d: obs=%b exp=%b", c, obs, exp);
      else passes++;
    end
    checks++;
    if (stall_cycles !== 32'd4)
      $display("FAIL mdu_count: stall_cycles=%0d exp=4", stall_cycles);
    else passes++;
    @(negedge clk); ex_mdu = 0; #1;
    checks++;
    if (obs !== 12'b0)
      $display("FAIL mdu_after: obs=%b exp=%b", obs, 12'b0);
    else passes++;
  endtask

  task automatic test_mdu_dmem_hold();
    logic [11:0] exp;
    do_reset();
    ex_mdu = 1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      dmem_wait = (c >= 3 && c <= 5);
      if (c == 7) ex_mdu = 0;
      #1;
      case (c)
        0:       exp = 12'b1_0011_0100_100;
        1, 2:    exp = 12'b1_0011_0100_000;
        3:       exp = 12'b1_0111_1000_000;
        4, 5:    exp = 12'b1_0111_1000_001;
        6:       exp = 12'b0_0000_0000_001;
        default: exp = 12'b0;
      endcase
      checks++;
      if (obs !== exp)
        $display("FAIL mdu_hold_cycle%0d: obs=%b exp=%b", c, obs, exp);
      else passes++;
    end
  endtask

  task automatic test_trap_priority();
    do_reset();
    ex_mdu = 1;
    @(negedge clk);
    mem_trap = 1; dmem_wait = 1; ex_redirect = 1; imem_wait = 1;
    ex_is_load = 1; ex_rd = 2; id_rs1 = 2; id_rs1_en = 1;
    #1;
    checks++;
    if (obs !== 12'b0_0000_1111_010)
      $display("FAIL trap_in_busy: obs=%b exp=%b", obs, 12'b0_0000_1111_010);
    else passes++;
    @(negedge clk); idle(); #1;
    checks++;
    if (obs !== 12'b0)
      $display("FAIL trap_next_run: obs=%b exp=%b", obs, 12'b0);
    else passes++;
  endtask

  task automatic test_redirect_wrap();
    do_reset();
    ex_redirect = 1; imem_wait = 1;
    #1;
    checks++;
    if (obs !== 12'b0_0000_0011_000)
      $display("FAIL redirect_over_imem: obs=%b exp=%b", obs, 12'b0_0000_0011_000);
    else passes++;
    @(negedge clk); ex_redirect = 0; #1;
    checks++;
    if (obs !== 12'b1_0000_0001_000)
      $display("FAIL imem_wait_alone: obs=%b exp=%b", obs, 12'b1_0000_0001_000);
    else passes++;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    checks++;
    if (stall_cycles2 !== 2'd3)
      $display("FAIL wrap_at_max: stall_cycles=%0d exp=3", stall_cycles2);
    else passes++;
    @(negedge clk); imem_wait = 0; #1;
    checks++;
    if (stall_cycles2 !== 2'd0)
      $display("FAIL wrap_to_zero: stall_cycles=%0d exp=0", stall_cycles2);
    else passes++;
    checks++;
    if (stall_cycles !== 32'd4)
      $display("FAIL wide_no_wrap: stall_cycles=%0d exp=4", stall_cycles);
    else passes++;
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_load_use();
    test_mdu();
    test_mdu_dmem_hold();
    test_trap_priority();
    test_redirect_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard/sequencing unit for the 5-stage in-order pipeline (IF/ID/EX/MEM/WB).
- Drives the stall and flush inputs of the four inter-stage flush/stall registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.
- Resolves load-use hazards, instruction/data memory wait, branch redirect, MEM-stage traps and the multi-cycle MDU occupancy of EX.
- Keeps a stall-cycle performance counter.

Parameters:
- MDU_LAT, 4, number of cycles an MDU instruction stalls in EX; legal range >= 2.
- CNT_W, 32, width of the stall-cycle performance counter.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- imem_wait  in  1  fetch not ready this cycle.
- dmem_wait  in  1  MEM-stage data access not ready this cycle.
- id_rs1  in  REG_W  ID source 1 index.
- id_rs1_en  in  1  ID uses rs1.
- id_rs2  in  REG_W  ID source 2 index.
- id_rs2_en  in  1  ID uses rs2.
- ex_rd  in  REG_W  EX destination index.
- ex_is_load  in  1  EX instruction is a load.
- ex_mdu  in  1  EX holds a valid MUL/DIV instruction.
- ex_redirect  in  1  EX branch/jump mispredict; PC loads target this cycle.
- mem_trap  in  1  MEM instruction raises exception/interrupt.
- pc_stall  out  1  hold PC.
- stall  out  4  [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB hold.
- flush  out  4  same indexing; insert bubble.
- mdu_start  out  1  one-cycle pulse that launches the MDU.
- mdu_kill  out  1  one-cycle pulse that aborts an in-flight MDU op.
- mdu_done  out  1  EX may capture the MDU result this cycle.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.

Behaviour:
- All stall/flush/pc_stall/mdu_* outputs are combinational from inputs and state. The register is state, cnt, stall_cycles.
- While rst=1: state=RUN, cnt=0, stall_cycles=0, flush=4'b1111, stall=0, pc_stall=1, mdu_start=0, mdu_kill=0, mdu_done=0.
- Condition priority, highest first. Exactly one row applies. Any bit not set by that row is 0.
  1. mem_trap: flush=4'b1111; pc_stall=0 (PC loads trap vector). If state!=RUN: mdu_kill=1 and next state=RUN.
  2. dmem_wait: stall=4'b0111; flush[3]=1; pc_stall=1.
  3. mdu_busy (see FSM): stall=4'b0011; flush[2]=1; pc_stall=1.
  4. ex_redirect: flush=4'b0011; pc_stall=0.
  5. load_use = ex_is_load & ex_rd!=0 & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)): stall=4'b0001; flush[1]=1; pc_stall=1.
  6. imem_wait: flush[0]=1; pc_stall=1.
  7. none: all zero.
- MDU FSM, states RUN/BUSY/DONE:
  - RUN & ex_mdu & !mem_trap & !dmem_wait: mdu_start=1, mdu_busy=1, cnt<=MDU_LAT-2, go BUSY.
  - BUSY: mdu_busy=1. If cnt==0, go DONE; else cnt<=cnt-1. The count continues while dmem_wait=1.
  - DONE: mdu_busy=0, mdu_done=1. Go RUN if dmem_wait=0; otherwise stay in DONE and hold the result.
  - Net effect: an MDU instruction stalls in EX for exactly MDU_LAT cycles and advances on cycle MDU_LAT+1.
  - mem_trap in BUSY or DONE: go RUN, mdu_kill=1, cnt unchanged/don't-care.
- stall_cycles increments by 1 each cycle pc_stall=1 and rst=0. It wraps modulo 2^CNT_W.
- Async rst mid-MDU: returns to RUN immediately. No mdu_kill pulse is issued; the MDU is reset by the same rst.

Decomposition:
- Package pipeline_ctrl_pkg:
  - stage index constants IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3;
  - enum mdu_state_t {RUN, BUSY, DONE}.
- Sub-module mdu_seq: MDU FSM and counter. Inputs ex_mdu, hold (=dmem_wait), kill (=mem_trap). Outputs mdu_busy, mdu_start, mdu_kill, mdu_done.
- Priority encoder and counter live in pipeline_ctrl.

Test Plan:
- Reset asserted mid-BUSY -> same cycle flush=4'b1111, pc_stall=1, stall_cycles=0. After release, state RUN and all outputs 0 with idle inputs.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_en=1 -> stall=4'b0001, flush=4'b0010, pc_stall=1. Same case with ex_rd=0 -> no stall.
- MDU_LAT=4, ex_mdu held high -> mdu_start on cycle 0; stall=4'b0011, flush=4'b0100 on cycles 0-3; mdu_done and no stall on cycle 4; stall_cycles=4.
- MDU BUSY, then dmem_wait high for 3 cycles spanning DONE -> stall=4'b0111 throughout, DONE held, mdu_done stays 1; instruction advances on the first cycle with dmem_wait=0.
- mem_trap with dmem_wait and ex_redirect together in BUSY -> flush=4'b1111, stall=0, pc_stall=0, mdu_kill=1, next state RUN.
- ex_redirect with imem_wait -> flush=4'b0011, pc_stall=0. Next cycle with imem_wait alone -> flush=4'b0001, pc_stall=1. Counter preloaded to 2^CNT_W-1 wraps to 0.
